// File: rtl/bcd_conv_seq.sv
// Sequential binary-to-BCD converter (double dabble, one input bit per clock)
// with a start/busy/done handshake, sticky overflow and leading-zero blanking.
module bcd_conv_seq #(
    parameter int DATA_W = 20,
    parameter int DIGITS = 6
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     data,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow,
    output logic [DIGITS-1:0]     blank_mask
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  LAST_SHIFT = CNT_W'(DATA_W - 1);
    localparam logic [DIGITS-1:0] MASK_RST   = {DIGITS{1'b1}} << 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   bin_q, bin_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                ovfWork_q, ovfWork_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ACC_W-1:0]    bcd_q, bcd_d;
    logic                ovfOut_q, ovfOut_d;
    logic [DIGITS-1:0]   mask_q, mask_d;
    logic                done_q, done_d;

    logic [ACC_W-1:0]    accAdj;
    logic [DIGITS-1:0]   maskCalc;
    logic                allZero;
    logic                accept;

    // Add-3 correction applied to every digit before it is doubled by the shift.
    always_comb begin
        accAdj = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                accAdj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Walk from the top digit down; a digit is blanked while everything above it is zero.
    always_comb begin
        allZero  = 1'b1;
        maskCalc = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            allZero     = allZero & (acc_q[4*i +: 4] == 4'd0);
            maskCalc[i] = allZero;
        end
        maskCalc[0] = 1'b0;
    end

    assign accept = start && (state_q != SHIFT);

    // Next-state logic: results are published while leaving DONE, so a
    // back-to-back accept on that same edge cannot disturb them.
    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        acc_d     = acc_q;
        ovfWork_d = ovfWork_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        ovfOut_d  = ovfOut_q;
        mask_d    = mask_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d     = {accAdj[ACC_W-2:0], bin_q[DATA_W-1]};
                bin_d     = bin_q << 1;
                ovfWork_d = ovfWork_q | accAdj[ACC_W-1];
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_SHIFT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d    = acc_q;
                ovfOut_d = ovfWork_q;
                mask_d   = maskCalc;
                done_d   = 1'b1;
                state_d  = accept ? SHIFT : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            bin_d     = data;
            acc_d     = '0;
            ovfWork_d = 1'b0;
            cnt_d     = '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            acc_q     <= '0;
            ovfWork_q <= 1'b0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            ovfOut_q  <= 1'b0;
            mask_q    <= MASK_RST;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            acc_q     <= acc_d;
            ovfWork_q <= ovfWork_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            ovfOut_q  <= ovfOut_d;
            mask_q    <= mask_d;
            done_q    <= done_d;
        end
    end

    assign busy       = (state_q == SHIFT);
    assign done       = done_q;
    assign bcd        = bcd_q;
    assign overflow   = ovfOut_q;
    assign blank_mask = mask_q;

endmodule

// File: tb/tb_bcd_conv_seq.sv
// Self-checking bench for bcd_conv_seq: directed scenarios plus random values
// checked against a decimal-arithmetic reference model.
module tb_bcd_conv_seq;

    logic        sys_clk;
    logic        sys_rst;
    logic        start;
    logic [19:0] data;
    logic        busy;
    logic        done;
    logic [23:0] bcd;
    logic        overflow;
    logic [5:0]  blank_mask;

    int nCompared;
    int nMismatched;

    bcd_conv_seq #(.DATA_W(20), .DIGITS(6)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .start      (start),
        .data       (data),
        .busy       (busy),
        .done       (done),
        .bcd        (bcd),
        .overflow   (overflow),
        .blank_mask (blank_mask)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Reference model: plain decimal arithmetic on the integer value.
    function automatic logic [23:0] modelBcd(input int unsigned v);
        int unsigned r;
        logic [23:0] b;
        r = v % 1000000;
        b = '0;
        for (int i = 0; i < 6; i++) begin
            b[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return b;
    endfunction

    function automatic logic modelOvf(input int unsigned v);
        return (v >= 1000000) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic [5:0] modelMask(input int unsigned v);
        int unsigned r;
        int unsigned p;
        logic [5:0] m;
        r = v % 1000000;
        p = 1;
        m = '0;
        for (int i = 1; i < 6; i++) begin
            p = p * 10;
            m[i] = (r < p) ? 1'b1 : 1'b0;
        end
        return m;
    endfunction

    // Presents start for one accept edge; returns just after that edge.
    task automatic applyStimulus(input logic [19:0] v);
        @(negedge sys_clk);
        start = 1'b1;
        data  = v;
        @(posedge sys_clk);
    endtask

    // Samples outputs on the falling edge for n cycles after an accept edge.
    task automatic observe(input int n, output int busyCnt, output int firstDone,
                           output int doneCnt, output logic [23:0] bcdAt,
                           output logic ovfAt, output logic [5:0] maskAt);
        busyCnt   = 0;
        firstDone = -1;
        doneCnt   = 0;
        bcdAt     = 'x;
        ovfAt     = 1'bx;
        maskAt    = 'x;
        for (int k = 0; k < n; k++) begin
            @(negedge sys_clk);
            if (k == 0) start = 1'b0;
            if (busy === 1'b1) busyCnt++;
            if (done === 1'b1) begin
                doneCnt++;
                if (firstDone < 0) begin
                    firstDone = k;
                    bcdAt     = bcd;
                    ovfAt     = overflow;
                    maskAt    = blank_mask;
                end
            end
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        nCompared++; if (bcd !== 24'h0) begin nMismatched++; $display("[TB] FAIL reset_bcd got %h want %h", bcd, 24'h0); end
        nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        nCompared++; if (done !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_done got %b want 0", done); end
        nCompared++; if (overflow !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_ovf got %b want 0", overflow); end
        nCompared++; if (blank_mask !== 6'b111110) begin nMismatched++; $display("[TB] FAIL reset_mask got %b want 111110", blank_mask); end
        sys_rst = 1'b0;
    endtask

    task automatic test_basic(input int unsigned v, input string name);
        int bc, fd, dc;
        logic [23:0] b;
        logic o;
        logic [5:0] m;
        applyStimulus(20'(v));
        observe(30, bc, fd, dc, b, o, m);
        nCompared++; if (bc !== 20) begin nMismatched++; $display("[TB] FAIL %s_busy_cycles got %0d want 20", name, bc); end
        nCompared++; if (fd !== 21) begin nMismatched++; $display("[TB] FAIL %s_done_pos got %0d want 21", name, fd); end
        nCompared++; if (dc !== 1) begin nMismatched++; $display("[TB] FAIL %s_done_count got %0d want 1", name, dc); end
        nCompared++; if (b !== modelBcd(v)) begin nMismatched++; $display("[TB] FAIL %s_bcd got %h want %h", name, b, modelBcd(v)); end
        nCompared++; if (o !== modelOvf(v)) begin nMismatched++; $display("[TB] FAIL %s_ovf got %b want %b", name, o, modelOvf(v)); end
        nCompared++; if (m !== modelMask(v)) begin nMismatched++; $display("[TB] FAIL %s_mask got %b want %b", name, m, modelMask(v)); end
    endtask

    task automatic test_back_to_back();
        int doneAt [$];
        logic [23:0] bcdAt [$];
        logic [5:0] maskAt [$];
        logic busyAfter;
        applyStimulus(20'd999999);
        busyAfter = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge sys_clk);
            if (k == 0) data = 20'd0;
            if (k == 21) begin
                busyAfter = busy;
                start = 1'b0;
            end
            if (done === 1'b1) begin
                doneAt.push_back(k);
                bcdAt.push_back(bcd);
                maskAt.push_back(blank_mask);
            end
        end
        nCompared++; if (doneAt.size() !== 2) begin nMismatched++; $display("[TB] FAIL b2b_done_count got %0d want 2", doneAt.size()); end
        if (doneAt.size() >= 2) begin
            nCompared++; if (bcdAt[0] !== 24'h999999) begin nMismatched++; $display("[TB] FAIL b2b_first_bcd got %h want 999999", bcdAt[0]); end
            nCompared++; if (doneAt[1] - doneAt[0] !== 21) begin nMismatched++; $display("[TB] FAIL b2b_spacing got %0d want 21", doneAt[1] - doneAt[0]); end
            nCompared++; if (bcdAt[1] !== 24'h000000) begin nMismatched++; $display("[TB] FAIL b2b_second_bcd got %h want 000000", bcdAt[1]); end
            nCompared++; if (maskAt[1] !== 6'b111110) begin nMismatched++; $display("[TB] FAIL b2b_second_mask got %b want 111110", maskAt[1]); end
        end
        nCompared++; if (busyAfter !== 1'b1) begin nMismatched++; $display("[TB] FAIL b2b_no_idle busy got %b want 1", busyAfter); end
    endtask

    task automatic test_start_ignored();
        int dc, fd;
        logic [23:0] b;
        applyStimulus(20'd654321);
        dc = 0;
        fd = -1;
        b  = 'x;
        for (int k = 0; k < 45; k++) begin
            @(negedge sys_clk);
            start = (k == 4) ? 1'b1 : 1'b0;
            if (k == 4) data = 20'd111111;
            if (done === 1'b1) begin
                dc++;
                if (fd < 0) begin fd = k; b = bcd; end
            end
        end
        nCompared++; if (dc !== 1) begin nMismatched++; $display("[TB] FAIL ignore_done_count got %0d want 1", dc); end
        nCompared++; if (fd !== 21) begin nMismatched++; $display("[TB] FAIL ignore_done_pos got %0d want 21", fd); end
        nCompared++; if (b !== 24'h654321) begin nMismatched++; $display("[TB] FAIL ignore_bcd got %h want 654321", b); end
    endtask

    task automatic test_reset_abort();
        int dc;
        applyStimulus(20'd987654);
        for (int k = 0; k < 10; k++) begin
            @(negedge sys_clk);
            if (k == 0) start = 1'b0;
            if (k == 9) sys_rst = 1'b1;
        end
        @(negedge sys_clk);
        sys_rst = 1'b0;
        nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL abort_busy got %b want 0", busy); end
        nCompared++; if (bcd !== 24'h0) begin nMismatched++; $display("[TB] FAIL abort_bcd got %h want 0", bcd); end
        dc = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge sys_clk);
            if (done === 1'b1) dc++;
        end
        nCompared++; if (dc !== 0) begin nMismatched++; $display("[TB] FAIL abort_done_count got %0d want 0", dc); end
        test_basic(42, "after_abort");
    endtask

    task automatic test_random();
        int unsigned v;
        for (int n = 0; n < 24; n++) begin
            case (n % 4)
                0: v = $urandom_range(0, 999);
                1: v = $urandom_range(0, 999999);
                default: v = $urandom_range(0, 1048575);
            endcase
            test_basic(v, "random");
        end
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        start       = 1'b0;
        data        = '0;
        sys_rst     = 1'b1;
        test_reset();
        test_basic(123456, "basic");
        test_back_to_back();
        test_basic(1048575, "overflow");
        test_basic(1000000, "ovf_edge");
        test_basic(999999, "max_fit");
        test_start_ignored();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
